// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store unit controller between a CPU port and a word-wide memory port.
//   Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned H/W accesses fault).
//   Ports:
//     clk, rst                         clock, async active-high reset
//     cpu_req/we/funct3/addr/wdata     CPU command, sampled only in IDLE
//     cpu_busy/done/fault/rdata        CPU status and registered load result
//     mem_req/we/addr/be/wdata         memory request, held until mem_gnt
//     mem_gnt, mem_rvalid, mem_rdata   memory grant and load response
module lsu_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_funct3,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_fault,
    output logic [31:0]       cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t r_state, w_next;
    logic              r_we, r_fault;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata, r_rdata, w_load;
    logic              w_legal, w_misalign, w_fault;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [3:0]        w_be;

    // Stores only allow B/H/W; loads additionally allow BU/HU.
    assign w_legal = cpu_we ? (cpu_funct3 <= 3'd2) : (cpu_funct3 != 3'd3 && cpu_funct3 < 3'd6);
`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = (cpu_funct3[1:0] == 2'b01 && cpu_addr[0]) ||
                        (cpu_funct3 == 3'd2 && cpu_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif
    assign w_fault = !w_legal || w_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (cpu_req) w_next = w_fault ? DONE : REQ;
            REQ:     if (mem_gnt) w_next = r_we ? DONE : WAIT;
            WAIT:    if (mem_rvalid) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    assign w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign w_load = r_funct3 == 3'd0 ? {{24{w_byte[7]}}, w_byte} :
                    r_funct3 == 3'd4 ? {24'b0, w_byte} :
                    r_funct3 == 3'd1 ? {{16{w_half[15]}}, w_half} :
                    r_funct3 == 3'd5 ? {16'b0, w_half} : mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_fault  <= 1'b0;
        end else if (r_state == IDLE && cpu_req) begin
            r_we     <= cpu_we;
            r_funct3 <= cpu_funct3;
            r_addr   <= cpu_addr;
            r_wdata  <= cpu_wdata;
            r_fault  <= w_fault;
            if (w_fault) r_rdata <= 32'd0;
        end else if (r_state == WAIT && mem_rvalid) begin
            r_rdata <= w_load;
        end
    end

    // Low address bits select lanes only; H ignores addr[0] and W ignores addr[1:0].
    assign w_be = r_funct3[1:0] == 2'b00 ? 4'b0001 << r_addr[1:0] :
                  r_funct3[1:0] == 2'b01 ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'hF;

    assign cpu_busy  = r_state != IDLE;
    assign cpu_done  = r_state == DONE;
    assign cpu_fault = cpu_done && r_fault;
    assign cpu_rdata = r_rdata;
    assign mem_req   = r_state == REQ;
    assign mem_we    = mem_req && r_we;
    assign mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_be    = mem_req ? (r_we ? w_be : 4'hF) : 4'h0;
    assign mem_wdata = r_funct3[1:0] == 2'b00 ? {4{r_wdata[7:0]}} :
                       r_funct3[1:0] == 2'b01 ? {2{r_wdata[15:0]}} : r_wdata;
endmodule
